// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and glitch-filter the pad lines, frame
// 11-bit words with odd-parity/stop/timeout checks, and queue good bytes in a show-ahead FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_AW        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PS2_CLK,
  input  logic               PS2_DAT,
  input  logic               rd_en,
  input  logic               err_clr,
  output logic [7:0]         kbdcode,
  output logic               kbdcodeValid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow,
  output logic [2:0]         status
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam int                 TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]         FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0]      TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Index 0 carries PS2_CLK, index 1 carries PS2_DAT.
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_filt;
  logic [3:0]          r_fcnt [2];
  logic                r_clk_prev;

  state_t              r_state;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_par;
  logic [TW-1:0]       r_to_cnt;

  logic [7:0]          r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_count;

  logic w_fall;
  logic w_dat;
  logic w_timeout;
  logic w_stop_fall;
  logic w_par_ok;
  logic w_par_bad;
  logic w_frame_ev;
  logic w_good;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovf;

  assign w_fall      = r_clk_prev & ~r_filt[0];
  assign w_dat       = r_filt[1];
  assign w_timeout   = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
  assign w_stop_fall = w_fall && (r_state == S_STOP);
  assign w_par_ok    = ^{r_shift, r_par};
  assign w_par_bad   = w_stop_fall && !w_par_ok;
  assign w_frame_ev  = (w_stop_fall && w_par_ok && !w_dat) || w_timeout;
  assign w_good      = w_stop_fall && w_par_ok && w_dat;

  assign w_full      = r_count[FIFO_AW];
  assign w_pop       = rd_en && (r_count != '0);
  // A full FIFO still accepts a byte when a pop frees the head slot at the same edge.
  assign w_wr        = w_good && (!w_full || w_pop);
  assign w_ovf       = w_good && w_full && !w_pop;

  assign kbdcode      = r_mem[r_rd_ptr];
  assign kbdcodeValid = (r_count != '0);
  assign fifo_count   = r_count;

  // Two-flop synchroniser and run-length glitch filter for both pad lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_filt     <= 2'b11;
      r_fcnt[0]  <= 4'd0;
      r_fcnt[1]  <= 4'd0;
      r_clk_prev <= 1'b1;
    end else begin
      r_sync1    <= {PS2_DAT, PS2_CLK};
      r_sync2    <= r_sync1;
      r_clk_prev <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= 4'd0;
        end else if (r_fcnt[i] == FLT_LAST) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= 4'd0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end

  // Frame state machine and inter-edge timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_fall || (r_state == S_IDLE)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      if (w_timeout) begin
        r_state <= S_IDLE;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!w_dat) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state   <= S_IDLE;
            end
          end
          S_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_PARITY: begin
            r_par   <= w_dat;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  // Fault pulses and sticky status; a new fault outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      status     <= 3'b000;
    end else begin
      parity_err <= w_par_bad;
      frame_err  <= w_frame_ev;
      overflow   <= w_ovf;
      status     <= {w_ovf, w_frame_ev, w_par_bad} | (err_clr ? 3'b000 : status);
    end
  end

  // Show-ahead FIFO storage, pointers and exact occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end else begin
        r_wr_ptr        <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + {{FIFO_AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{FIFO_AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames driven with a half-period of HALF clk cycles,
// expected values hand-computed and compared through one checking task.
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int FIFO_AW        = 3;
  localparam int HALF           = 20;
  // Edges from the pad falling (driven at a negedge) to the write edge: 2 sync + 4 filter + 1.
  localparam int FALL_LAT       = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic               PS2_CLK;
  logic               PS2_DAT;
  logic               rd_en;
  logic               err_clr;
  logic [7:0]         kbdcode;
  logic               kbdcodeValid;
  logic [FIFO_AW:0]   fifo_count;
  logic               parity_err;
  logic               frame_err;
  logic               overflow;
  logic [2:0]         status;

  int n_checks = 0;
  int n_errors = 0;
  int n_par    = 0;
  int n_frm    = 0;
  int n_ovf    = 0;
  int s_par, s_frm, s_ovf;

  logic             obs_v6, obs_v7;
  logic [7:0]       obs_code7;
  logic [FIFO_AW:0] obs_cnt7;

  ps2_rx_fifo #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FIFO_AW        (FIFO_AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PS2_CLK      (PS2_CLK),
    .PS2_DAT      (PS2_DAT),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .kbdcode      (kbdcode),
    .kbdcodeValid (kbdcodeValid),
    .fifo_count   (fifo_count),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .status       (status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err) n_par++;
    if (frame_err)  n_frm++;
    if (overflow)   n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_par = n_par;
    s_frm = n_frm;
    s_ovf = n_ovf;
  endtask

  task automatic ps2_bit(input logic b, input logic glitch);
    PS2_DAT = b;
    if (glitch) begin
      wait_cyc(HALF / 2);
      PS2_CLK = 1'b0;
      wait_cyc(1);
      PS2_CLK = 1'b1;
      wait_cyc(HALF - HALF / 2 - 1);
    end else begin
      wait_cyc(HALF);
    end
    PS2_CLK = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  // Full frame; the stop-bit fall is timed so rd_en can coincide with the push edge.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                            input logic pop, input logic [10:0] gl);
    logic p;
    p = (~^d) ^ par_flip;
    ps2_bit(1'b0, gl[0]);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], gl[i+1]);
    ps2_bit(p, gl[9]);
    PS2_DAT = stop_b;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    repeat (FALL_LAT - 1) @(posedge clk);
    @(negedge clk);
    obs_v6 = kbdcodeValid;
    rd_en  = pop;
    @(negedge clk);
    rd_en     = 1'b0;
    obs_v7    = kbdcodeValid;
    obs_code7 = kbdcode;
    obs_cnt7  = fifo_count;
    wait_cyc(HALF - FALL_LAT);
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  initial begin
    int k;
    logic [7:0] exp_b;
    reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    wait_cyc(3);
    check("rst_valid", kbdcodeValid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_code", kbdcode, 0);
    check("rst_status", status, 0);
    check("rst_pulses", {parity_err, frame_err, overflow}, 0);
    reset = 1'b0;
    wait_cyc(10);

    // Valid 0x1C with exact push latency.
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11'd0);
    check("t1_valid_before", obs_v6, 0);
    check("t1_valid_after", obs_v7, 1);
    check("t1_code", obs_code7, 8'h1C);
    check("t1_count", obs_cnt7, 1);
    check("t1_no_err", (n_par - s_par) + (n_frm - s_frm) + (n_ovf - s_ovf), 0);
    pop_one();
    check("t1_pop_count", fifo_count, 0);
    pop_one();
    check("t1_empty_pop_count", fifo_count, 0);
    check("t1_empty_pop_status", status, 0);

    // Bad parity, then clear.
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 11'd0);
    check("t2_par_pulses", n_par - s_par, 1);
    check("t2_frm_pulses", n_frm - s_frm, 0);
    check("t2_status", status, 3'b001);
    check("t2_valid", kbdcodeValid, 0);
    err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0;
    check("t2_status_clr", status, 0);

    // Bad stop, then both bad (parity wins).
    snap();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 11'd0);
    check("t3_frm_pulses", n_frm - s_frm, 1);
    check("t3_par_pulses", n_par - s_par, 0);
    check("t3_status", status, 3'b010);
    check("t3_valid", kbdcodeValid, 0);
    snap();
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 11'd0);
    check("t3b_par_pulses", n_par - s_par, 1);
    check("t3b_frm_pulses", n_frm - s_frm, 0);
    check("t3b_status", status, 3'b011);
    err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0;

    // Timeout after start + 5 data bits.
    snap();
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    PS2_DAT = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    k = 0;
    while (k < FALL_LAT + TIMEOUT_CYCLES + 50) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == HALF) PS2_CLK = 1'b1;
      if (frame_err) break;
    end
    check("t4_timeout_latency", k, FALL_LAT + TIMEOUT_CYCLES);
    wait_cyc(1);
    check("t4_pulse_width", frame_err, 0);
    check("t4_frm_pulses", n_frm - s_frm, 1);
    check("t4_status", status, 3'b010);
    PS2_DAT = 1'b1;
    wait_cyc(2 * HALF);
    err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 11'd0);
    check("t4_next_code", obs_code7, 8'h5A);
    check("t4_next_count", obs_cnt7, 1);
    pop_one();

    // Fill past full: 0x01..0x09.
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) snap();
      send_frame(8'(i), 1'b0, 1'b1, 1'b0, 11'd0);
    end
    check("t5_count_full", fifo_count, 8);
    check("t5_ovf_pulses", n_ovf - s_ovf, 1);
    check("t5_status", status, 3'b100);
    check("t5_head", kbdcode, 8'h01);
    // Push and pop together while full.
    snap();
    send_frame(8'h0A, 1'b0, 1'b1, 1'b1, 11'd0);
    check("t5_fullpp_count", obs_cnt7, 8);
    check("t5_fullpp_head", obs_code7, 8'h02);
    check("t5_fullpp_ovf", n_ovf - s_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(i + 2) : 8'h0A;
      check("t5_drain", kbdcode, exp_b);
      pop_one();
    end
    check("t5_drained_valid", kbdcodeValid, 0);
    check("t5_drained_count", fifo_count, 0);
    err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0;

    // Push and pop together at count 1.
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 11'd0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 11'd0);
    check("t6_pp1_count", obs_cnt7, 1);
    check("t6_pp1_head", obs_code7, 8'h55);
    pop_one();

    // Clock glitches mid-frame.
    snap();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 11'b001_0010_0100);
    check("t7_glitch_code", obs_code7, 8'h3C);
    check("t7_glitch_count", obs_cnt7, 1);
    check("t7_glitch_err", (n_par - s_par) + (n_frm - s_frm), 0);

    // Reset mid-frame with one byte queued.
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("t8_rst_valid", kbdcodeValid, 0);
    check("t8_rst_count", fifo_count, 0);
    check("t8_rst_code", kbdcode, 0);
    PS2_DAT = 1'b1;
    PS2_CLK = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2 * HALF);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 11'd0);
    check("t8_next_code", obs_code7, 8'h29);
    check("t8_next_count", obs_cnt7, 1);
    check("t8_no_err", (n_par - s_par) + (n_frm - s_frm) + (n_ovf - s_ovf), 0);
    check("t8_status", status, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver with glitch filtering, odd-parity and stop-bit checking, and an inter-edge timeout. Received bytes go into a show-ahead FIFO so the consumer (the keyboard decoder feeding the VGA terminal) can drain them at its own pace. Framing, parity and overflow faults are reported as one-cycle pulses and as sticky status bits.

Parameters:
FILTER_LEN, 4, consecutive identical synchronised samples needed before the filtered PS2_CLK/PS2_DAT level changes (range 1..15).
TIMEOUT_CYCLES, 10000, clk cycles allowed between filtered PS2_CLK falling edges while a frame is in progress (≥2).
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries of 8 bits.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
PS2_CLK  in  1  raw PS/2 clock from pad, asynchronous.
PS2_DAT  in  1  raw PS/2 data from pad, asynchronous.
rd_en  in  1  pop request; honoured only when kbdcodeValid=1.
err_clr  in  1  clears the sticky status bits.
kbdcode  out  8  FIFO head byte; valid only when kbdcodeValid=1.
kbdcodeValid  out  1  FIFO not empty.
fifo_count  out  FIFO_AW+1  current occupancy, 0..2**FIFO_AW.
parity_err  out  1  one-cycle pulse when a frame is rejected for bad parity.
frame_err  out  1  one-cycle pulse for a bad stop bit or a timeout.
overflow  out  1  one-cycle pulse when a good byte arrives with the FIFO full.
status  out  3  sticky {overflow, frame_err, parity_err}.

Behaviour:
- Reset (async assert; deassert taken at the next clk edge): state IDLE, FIFO empty, kbdcode=0, kbdcodeValid=0, fifo_count=0, all pulses 0, status=0, bit counter 0, timeout counter 0. Synchroniser and filter outputs reset to 1 (bus idle).
- Input path: 2-flop synchroniser per line, then a filter per line. The filtered level takes a new value only after FILTER_LEN consecutive synchronised samples equal that value. A fall is filtered clk 1→0 between consecutive cycles.
- All bits are sampled as filtered PS2_DAT in the cycle a fall is detected. The device changes data while PS2_CLK is high; the host samples on the falling edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with dat=0 → DATA, bit count cleared. Fall with dat=1 is ignored, with no error.
  - DATA: each fall shifts dat in LSB first. On the 8th fall → PARITY.
  - PARITY: fall captures the parity bit → STOP.
  - STOP: fall captures the stop bit → IDLE. If the XOR of the 8 data bits and the parity bit is 1 and stop=1, the byte is pushed. If parity is bad, parity_err pulses and the byte is discarded. Else if stop=0, frame_err pulses and the byte is discarded. Parity has priority when both are bad, so only parity_err pulses.
- Timeout: the counter clears on every fall and while in IDLE, and increments otherwise. When it reaches TIMEOUT_CYCLES in DATA/PARITY/STOP, frame_err pulses, the partial byte is discarded and the FSM returns to IDLE. A fall in the same cycle as the timeout takes precedence, so no timeout is flagged.
- Pulse timing: error and overflow pulses are asserted in the cycle after the decisive fall or timeout. Each pulse sets its status bit. err_clr clears status; a set event in the same cycle wins.
- FIFO: show-ahead. Push is registered, so kbdcode and kbdcodeValid update 1 cycle after the stop-bit fall.
  - rd_en while kbdcodeValid=1 pops at that edge. rd_en while empty is ignored, with no error.
  - Push when full and no pop: byte dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle when full: both occur and count is unchanged, with no overflow.
  - Push and pop in the same cycle when count=1: the new byte becomes head.
  - Pointers wrap modulo 2**FIFO_AW. fifo_count is exact at all times.
- Reset mid-frame: the frame is abandoned, FIFO contents are lost, and no pulse is issued.

Test Plan:
- Send a valid frame for 0x1C (parity 0, stop 1) with 40 µs half-periods → kbdcodeValid=1 and kbdcode=0x1C one cycle after the 11th fall; fifo_count=1; no error pulses.
- Send 0x1C with parity=1 → one parity_err pulse, status=3'b001, kbdcodeValid stays 0. Then assert err_clr → status=0.
- Send 0xF0 with stop=0 → frame_err pulse, status[1]=1, nothing pushed. Separately, stop the clock after 5 bits → frame_err exactly TIMEOUT_CYCLES after the last fall, FSM back in IDLE, and the next valid 0x5A is received correctly.
- With FIFO_AW=3, send 9 bytes 0x01..0x09 and no reads → fifo_count=8, one overflow pulse on byte 9. Draining 8 pops yields 0x01..0x08 in order, then kbdcodeValid=0.
- Inject 1-cycle glitches on PS2_CLK mid-frame with FILTER_LEN=4 → bytes are received unchanged and no extra bits are shifted. Assert reset mid-frame → all outputs at reset values immediately, and the next frame is received cleanly.
